sdram_wbuf_64b: RTL and testbench

Per-bank write-data staging buffer feeding the 64-bit SDRAM data path. Accepts 64-bit words with byte enables from a host port into a small FIFO, reports when a complete burst is resident, and, on each `data_fetch` pulse from the command sequencer (p0), presents the next word and byte enables at p2 on the `wr_data_bN` / `wr_bena_bN` inputs of the data path. One instance per bank (four total).

---
 rtl/sdram_wbuf_64b.sv | 104 ++++++++++
 tb/tb_sdram_wbuf_64b.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sdram_wbuf_64b.sv
// Per-bank 64-bit write-data staging FIFO with a two-stage fetch pipeline to the SDRAM data path.
// Optional sticky error detection is built when SDRAM_WBUF_ERR_EN is defined.
module sdram_wbuf_64b #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned BURST_LOG2 = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic [63:0]           host_data,
    input  logic [7:0]            host_bena,
    output logic                  burst_rdy,
    output logic [DEPTH_LOG2:0]   level,
    input  logic                  data_fetch,
    output logic [63:0]           wr_data,
    output logic [7:0]            wr_bena,
    output logic                  wr_err
);

    localparam int unsigned         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] BURST = (DEPTH_LOG2 + 1)'(1 << BURST_LOG2);
    localparam logic [DEPTH_LOG2:0] ONE   = (DEPTH_LOG2 + 1)'(1);

    logic [71:0]         mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q, level_q;
    logic                push, pop;
    logic                p1_valid_q;
    logic [71:0]         p1_word_q;

    assign host_ready = (level_q != FULL);
    assign burst_rdy  = (level_q >= BURST);
    assign level      = level_q;
    assign push       = host_valid & host_ready;
    assign pop        = data_fetch & (level_q != '0);

    // Storage carries no reset; contents are discarded by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {host_bena, host_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ONE;
            end
            if (push && !pop) begin
                level_q <= level_q + ONE;
            end else if (pop && !push) begin
                level_q <= level_q - ONE;
            end
        end
    end

    // p1 holds the read word, p2 drives the data path; idle cycles must be all-zero
    // because the banks are ORed together downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_q <= 1'b0;
            p1_word_q  <= '0;
            wr_data    <= '0;
            wr_bena    <= '0;
        end else begin
            p1_valid_q <= pop;
            if (pop) begin
                p1_word_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
            end
            if (p1_valid_q) begin
                wr_data <= p1_word_q[63:0];
                wr_bena <= p1_word_q[71:64];
            end else begin
                wr_data <= '0;
                wr_bena <= '0;
            end
        end
    end

`ifdef SDRAM_WBUF_ERR_EN
    logic wr_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else if ((data_fetch && level_q == '0) || (host_valid && !host_ready)) begin
            wr_err_q <= 1'b1;
        end
    end

    assign wr_err = wr_err_q;
`else
    assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_wbuf_64b.sv
// Directed and randomized bench for sdram_wbuf_64b against a queue-based reference model.
module tb_sdram_wbuf_64b;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_valid;
    logic        host_ready;
    logic [63:0] host_data;
    logic [7:0]  host_bena;
    logic        burst_rdy;
    logic [3:0]  level;
    logic        data_fetch;
    logic [63:0] wr_data;
    logic [7:0]  wr_bena;
    logic        wr_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents, word due at the outputs next cycle, current output word.
    logic [71:0] q[$];
    logic [71:0] exp_p1;
    logic [71:0] exp_out;
    logic        exp_err;

    sdram_wbuf_64b dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_data  (host_data),
        .host_bena  (host_bena),
        .burst_rdy  (burst_rdy),
        .level      (level),
        .data_fetch (data_fetch),
        .wr_data    (wr_data),
        .wr_bena    (wr_bena),
        .wr_err     (wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        exp_p1  = '0;
        exp_out = '0;
        exp_err = 1'b0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".level"}, 72'(level), 72'(q.size()));
        chk({tag, ".wr_data"}, 72'(wr_data), 72'(exp_out[63:0]));
        chk({tag, ".wr_bena"}, 72'(wr_bena), 72'(exp_out[71:64]));
`ifdef SDRAM_WBUF_ERR_EN
        chk({tag, ".wr_err"}, 72'(wr_err), 72'(exp_err));
`else
        chk({tag, ".wr_err"}, 72'(wr_err), 72'(1'b0));
`endif
    endtask

    // Called at posedge+1; applies inputs for one cycle and checks both before and after the edge.
    task automatic step(input logic hv, input logic [63:0] hd, input logic [7:0] hb,
                        input logic fe);
        logic do_push, do_pop;
        host_valid = hv;
        host_data  = hd;
        host_bena  = hb;
        data_fetch = fe;
        #2;
        chk("host_ready", 72'(host_ready), 72'(q.size() != 8));
        chk("burst_rdy", 72'(burst_rdy), 72'(q.size() >= 2));
        do_push = hv && (q.size() != 8);
        do_pop  = fe && (q.size() != 0);
        if ((fe && q.size() == 0) || (hv && q.size() == 8)) exp_err = 1'b1;
        @(posedge clk);
        #1;
        exp_out = exp_p1;
        exp_p1  = do_pop ? q[0] : 72'h0;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({hb, hd});
        chk_outputs("step");
        host_valid = 1'b0;
        data_fetch = 1'b0;
    endtask

    // Asserts reset asynchronously at the current time, releases it on the falling edge.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk({tag, ".host_ready"}, 72'(host_ready), 72'(1'b1));
        chk({tag, ".burst_rdy"}, 72'(burst_rdy), 72'(1'b0));
        chk_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_outputs({tag, "_rel"});
    endtask

    initial begin
        rst_n      = 1'b0;
        host_valid = 1'b0;
        host_data  = '0;
        host_bena  = '0;
        data_fetch = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        async_reset("reset0");

        // Two-word burst with known patterns
        step(1'b1, 64'h1111_1111_1111_1111, 8'hFF, 1'b0);
        step(1'b1, 64'h2222_2222_2222_2222, 8'h0F, 1'b0);
        chk("burst_after_push", 72'(burst_rdy), 72'(1'b1));
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        chk("burst_w0_data", 72'(wr_data), 72'(64'h1111_1111_1111_1111));
        chk("burst_w0_bena", 72'(wr_bena), 72'(8'hFF));
        step(1'b0, '0, '0, 1'b0);
        chk("burst_w1_data", 72'(wr_data), 72'(64'h2222_2222_2222_2222));
        chk("burst_w1_bena", 72'(wr_bena), 72'(8'h0F));
        step(1'b0, '0, '0, 1'b0);
        chk("burst_idle_data", 72'(wr_data), 72'(64'h0));

        // Fill to full, then push+fetch at full
        for (int i = 0; i < 8; i++) step(1'b1, {$urandom, $urandom}, 8'($urandom), 1'b0);
        chk("full_level", 72'(level), 72'(8));
        chk("full_ready", 72'(host_ready), 72'(1'b0));
        step(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'hAA, 1'b1);
        chk("full_pushpop_level", 72'(level), 72'(7));
        for (int i = 0; i < 9; i++) step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        async_reset("reset1");

        // Underflow on empty FIFO
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0);
        chk("uflow_data", 72'(wr_data), 72'(64'h0));
        chk("uflow_level", 72'(level), 72'(0));
`ifdef SDRAM_WBUF_ERR_EN
        chk("uflow_err", 72'(wr_err), 72'(1'b1));
`else
        chk("uflow_err", 72'(wr_err), 72'(1'b0));
`endif
        async_reset("reset2");

        // Streaming 20 incrementing words through a shallow FIFO, exercising pointer wrap
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 64'(i), 8'hFF, i > 0);
            chk("stream_level_le2", 72'(level <= 4'd2), 72'(1'b1));
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, i == 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
                 1'($urandom_range(0, 1)));
        end

        // Reset asserted between fetch p0 and p2
        async_reset("reset3");
        step(1'b1, 64'h5555_5555_5555_5555, 8'hFF, 1'b0);
        step(1'b1, 64'h6666_6666_6666_6666, 8'hFF, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        async_reset("reset_midfetch");
        chk("midfetch_data", 72'(wr_data), 72'(64'h0));
        chk("midfetch_bena", 72'(wr_bena), 72'(8'h0));
        step(1'b0, '0, '0, 1'b0);
        chk("midfetch_after_data", 72'(wr_data), 72'(64'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
